booth_mult_seq: RTL and testbench

//   Sequential radix-2 Booth signed multiplier for the processor's MULT path.
//   It sits directly upstream of the shared 32-bit carry-lookahead adder (add_op).

---
 rtl/booth_mult_seq.sv | 160 ++++++++++++++++
 tb/tb_booth_mult_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// booth_mult_seq
//   Sequential radix-2 Booth signed multiplier. It uses an external shared
//   adder (add_op) for every step: each RUN cycle it drives add_a/add_b/add_cin
//   and takes add_sum back in the same cycle. Each operation takes WIDTH Booth
//   steps. It returns the low WIDTH bits of the signed product and a flag that
//   is set when the product does not fit in WIDTH signed bits.
//
// Ports
//   clock         rising-edge clock
//   reset_n       synchronous active-low reset
//   start         request; operands are sampled on the accepting edge
//   multiplicand  M, two's complement
//   multiplier    Q, two's complement
//   add_a/add_b   adder operands (zero outside RUN)
//   add_cin       adder carry-in (zero outside RUN)
//   add_sum       adder sum, combinational from add_a/add_b/add_cin
//   busy          high while the step sequence runs
//   done          one-cycle pulse; result/overflow are valid from this cycle
//   result        low WIDTH bits of M*Q, held until the next completion
//   overflow      product does not fit in signed WIDTH bits
module booth_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               q_m1_q, q_m1_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic               last_step;
  logic               add_ovf;
  logic               sum_sign;
  logic [WIDTH-1:0]   hi_sh;
  logic [WIDTH-1:0]   lo_sh;

  assign accept    = start && (state_q == S_IDLE || state_q == S_DONE);
  assign last_step = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

  // State register and datapath flops
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      q_m1_q   <= 1'b0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      q_m1_q   <= q_m1_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_step) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: status flags and adder operand selection
  always_comb begin
    busy    = (state_q == S_RUN);
    done    = (state_q == S_DONE);
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == S_RUN) begin
      add_a = hi_q;
      case ({lo_q[0], q_m1_q})
        2'b01: add_b = mcand_q;
        2'b10: begin
          add_b   = ~mcand_q;
          add_cin = 1'b1;
        end
        default: add_b = '0;
      endcase
    end
  end

  // The adder is only WIDTH bits wide; its signed overflow is used to recover
  // the true sign of the (WIDTH+1)-bit partial sum, which is what gets shifted
  // into hi. Without this, M = most-negative value would corrupt the product.
  always_comb begin
    add_ovf  = ~(add_a[WIDTH-1] ^ add_b[WIDTH-1]) & (add_sum[WIDTH-1] ^ add_a[WIDTH-1]);
    sum_sign = add_sum[WIDTH-1] ^ add_ovf;
    hi_sh    = {sum_sign, add_sum[WIDTH-1:1]};
    lo_sh    = {add_sum[0], lo_q[WIDTH-1:1]};
  end

  // Datapath next values
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    q_m1_d   = q_m1_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    if (accept) begin
      hi_d    = '0;
      lo_d    = multiplier;
      q_m1_d  = 1'b0;
      mcand_d = multiplicand;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      hi_d   = hi_sh;
      lo_d   = lo_sh;
      q_m1_d = lo_q[0];
      if (last_step) begin
        result_d = lo_sh;
        ovf_d    = (hi_sh != {WIDTH{lo_sh[WIDTH-1]}});
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign result   = result_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Testbench for booth_mult_seq: models the shared adder, runs a table of
// directed vectors, multi-cycle corner sequences and random operands checked
// against a plain 64-bit signed multiply.
module tb_booth_mult_seq;

  localparam int W = 32;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic [W-1:0]  add_a;
  logic [W-1:0]  add_b;
  logic          add_cin;
  logic [W-1:0]  add_sum;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          overflow;

  int passed = 0;
  int total  = 0;

  booth_mult_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_cin      (add_cin),
    .add_sum      (add_sum),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .overflow     (overflow)
  );

  // Shared carry-lookahead adder stand-in
  assign add_sum = add_a + add_b + {{(W-1){1'b0}}, add_cin};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] m;
    logic [W-1:0] q;
    logic [W-1:0] exp_r;
    logic         exp_o;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: full signed product, low word, and whether it fits in W bits
  function automatic logic [W:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
    longint       p;
    logic [W-1:0] lo;
    p  = longint'($signed(m)) * longint'($signed(q));
    lo = p[W-1:0];
    return {(p != longint'($signed(lo))), lo};
  endfunction

  // Launch one operation and wait for done. from_here=1 drives start in the
  // current cycle (used for back-to-back from DONE). pulse_at>0 re-asserts
  // start with junk operands that many edges into RUN.
  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                        input bit from_here, input int pulse_at,
                        output logic [W-1:0] r, output logic o, output int lat);
    if (!from_here) @(negedge clock);
    start = 1'b1; multiplicand = m; multiplier = q;
    @(posedge clock); #1;
    start = 1'b0; multiplicand = ~m; multiplier = ~q;
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    // First Booth step sees hi=0, q_m1=0, so only q[0] decides
    chk("first_add_a", {32'd0, add_a}, 64'd0);
    chk("first_add_b", {32'd0, add_b}, q[0] ? {32'd0, ~m} : 64'd0);
    chk("first_add_cin", {63'd0, add_cin}, {63'd0, q[0]});
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
      if (lat == pulse_at) begin
        start = 1'b1; multiplicand = $urandom; multiplier = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    r = result; o = overflow;
  endtask

  initial begin
    vec_t         vecs[9];
    logic [W-1:0] r;
    logic         o;
    int           lat;
    logic [W:0]   e;
    logic [W-1:0] m, q;
    int           seen;

    vecs[0] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b0};
    vecs[1] = '{32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFD6, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0};
    vecs[4] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b1};
    vecs[6] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};

    reset_n = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_add_ops", {add_cin, add_a, add_b[30:0]}, 64'd0);
    @(negedge clock); reset_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].m, vecs[i].q, 1'b0, 0, r, o, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
      chk($sformatf("vec%0d_result", i), {32'd0, r}, {32'd0, vecs[i].exp_r});
      chk($sformatf("vec%0d_overflow", i), {63'd0, o}, {63'd0, vecs[i].exp_o});
      chk($sformatf("vec%0d_busy_at_done", i), {63'd0, busy}, 64'd0);
    end

    // Idle after done: adder operands quiet
    @(posedge clock); #1;
    chk("idle_done_low", {63'd0, done}, 64'd0);
    chk("idle_add_ops", {add_cin, add_a, add_b[30:0]}, 64'd0);

    // start pulsed during RUN is ignored
    run_op(32'h0000_1234, 32'hFFFF_FF00, 1'b0, 5, r, o, lat);
    e = ref_mul(32'h0000_1234, 32'hFFFF_FF00);
    chk("ignore_start_latency", 64'(lat), 64'd32);
    chk("ignore_start_result", {32'd0, r}, {32'd0, e[W-1:0]});
    chk("ignore_start_overflow", {63'd0, o}, {63'd0, e[W]});

    // start during DONE: back-to-back operation
    run_op(32'h0000_0007, 32'h0000_0009, 1'b1, 0, r, o, lat);
    chk("b2b_latency", 64'(lat), 64'd32);
    chk("b2b_result", {32'd0, r}, 64'd63);
    chk("b2b_overflow", {63'd0, o}, 64'd0);

    // Reset in the middle of RUN
    @(negedge clock);
    start = 1'b1; multiplicand = 32'h0000_0021; multiplier = 32'h0000_0011;
    @(posedge clock); #1; start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock); reset_n = 1'b0;
    @(posedge clock); #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_result", {32'd0, result}, 64'd0);
    chk("midrst_overflow", {63'd0, overflow}, 64'd0);
    @(negedge clock); reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (done) seen++;
    end
    chk("midrst_no_done", 64'(seen), 64'd0);
    run_op(32'hFFFF_FFFD, 32'h0000_0004, 1'b0, 0, r, o, lat);
    chk("post_rst_latency", 64'(lat), 64'd32);
    chk("post_rst_result", {32'd0, r}, 64'h0000_0000_FFFF_FFF4);
    chk("post_rst_overflow", {63'd0, o}, 64'd0);

    // Random operands against the reference product
    for (int i = 0; i < 40; i++) begin
      m = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : 32'($urandom);
      q = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : 32'($urandom);
      e = ref_mul(m, q);
      run_op(m, q, bit'($urandom_range(0, 1)), 0, r, o, lat);
      chk($sformatf("rand%0d_latency", i), 64'(lat), 64'd32);
      chk($sformatf("rand%0d_result m=%h q=%h", i, m, q), {32'd0, r}, {32'd0, e[W-1:0]});
      chk($sformatf("rand%0d_overflow m=%h q=%h", i, m, q), {63'd0, o}, {63'd0, e[W]});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
